// File: rtl/lfsr_encrypt_engine_if.sv
// -----------------------------------------------------------------------------
// lfsr_encrypt_engine_if
//
// Purpose: bundles the launch handshake (req/ack) and the data-memory port of
// the LFSR encryption engine. The engine masters the memory port and answers
// the launch request, so it connects through the master modport. The
// processor/memory side (or a testbench) connects through the slave modport.
//
// Signals:
//   req        start request from the launcher, level sensitive
//   ack        run complete, held until req drops
//   mem_addr   8-bit data-memory address
//   mem_we     data-memory write enable
//   mem_wdata  8-bit write data
//   mem_rdata  8-bit read data, valid one cycle after mem_addr (sync read)
// -----------------------------------------------------------------------------
interface lfsr_encrypt_engine_if;
   logic       req;
   logic       ack;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   modport master (
      input  req,
      input  mem_rdata,
      output ack,
      output mem_addr,
      output mem_we,
      output mem_wdata
   );

   modport slave (
      output req,
      output mem_rdata,
      input  ack,
      input  mem_addr,
      input  mem_we,
      input  mem_wdata
   );
endinterface

// File: rtl/lfsr_encrypt_engine.sv
// -----------------------------------------------------------------------------
// lfsr_encrypt_engine
//
// Purpose: fixed-function LFSR encryptor. On a req launch it reads the three
// configuration bytes (pre_length at 61, taps at 62, seed at 63), then produces
// 64 ciphertext bytes at DM[64..127]. Plaintext byte i is a space when it falls
// in the pre-pad region or past the 61-byte message, otherwise DM[i-pre_length].
// Ciphertext is the low 7 plaintext bits XOR the 7-bit LFSR state, with even
// parity of those 7 bits placed in bit 7.
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   init  synchronous active-low reset (0 = reset)
//   bus   lfsr_encrypt_engine_if.master: req/ack handshake + data-memory port
//
// Timing: the edge that samples req in IDLE is E0. CFG0..CFG3 take four cycles,
// each byte takes a RD cycle (address out) and a WR cycle (write strobe), and
// ack rises one cycle after the FSM enters DONE, i.e. after edge E0+133.
// mem_wdata is formed combinationally in WR because the byte it encrypts only
// arrives on mem_rdata during that same cycle; outside WR it is forced to 0.
// -----------------------------------------------------------------------------
module lfsr_encrypt_engine (
   input logic                    clk,
   input logic                    init,
   lfsr_encrypt_engine_if.master  bus
);

   localparam logic [7:0] CFG_BASE = 8'd61;
   localparam logic [7:0] OUT_BASE = 8'd64;
   localparam logic [7:0] MSG_LAST = 8'd60;   // last valid message offset
   localparam logic [5:0] LAST_IDX = 6'd63;   // N_OUT - 1
   localparam logic [6:0] SPACE7   = 7'h20;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CFG0 = 3'd1,
      CFG1 = 3'd2,
      CFG2 = 3'd3,
      CFG3 = 3'd4,
      RD   = 3'd5,
      WR   = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t     state_r;
   logic [7:0] pre_len_r;
   logic [6:0] taps_r;
   logic [6:0] lfsr_r;
   logic [5:0] idx_r;
   logic       space_r;     // current byte is a pad space, mem_rdata ignored
   logic       ack_r;
   logic       we_r;
   logic [7:0] addr_r;

   logic [5:0] src_idx_s;   // byte index whose source is being resolved
   logic [8:0] src_s;       // {space, read address} for src_idx_s
   logic [6:0] seed_s;
   logic [6:0] plain_s;
   logic [6:0] cipher_s;
   logic [6:0] lfsr_next_s;
   logic [7:0] wdata_s;

   // Even parity over the 7 ciphertext bits.
   function automatic logic parity7(input logic [6:0] v);
      return ^v;
   endfunction

   // One Fibonacci-style LFSR step: shift left, feedback is XOR of tapped bits.
   function automatic logic [6:0] lfsr_step(input logic [6:0] s,
                                             input logic [6:0] taps);
      return {s[5:0], ^(s & taps)};
   endfunction

   // Resolves where plaintext byte idx comes from. The comparison is done
   // before the subtraction so idx - pre never wraps in 8 bits.
   function automatic logic [8:0] plain_src(input logic [5:0] idx,
                                             input logic [7:0] pre);
      logic [7:0] idx8;
      logic [7:0] diff;
      logic       space;
      idx8 = {2'b00, idx};
      if (idx8 < pre) begin
         space = 1'b1;
         diff  = 8'd0;
      end else begin
         diff  = idx8 - pre;
         space = (diff > MSG_LAST);
      end
      if (space) begin
         return {1'b1, 8'd0};
      end else begin
         return {1'b0, diff};
      end
   endfunction

   // Source lookup for the byte about to enter RD (byte 0 from CFG3, else next).
   always_comb begin
      src_idx_s = 6'd0;
      if (state_r == CFG3) begin
         src_idx_s = 6'd0;
      end else begin
         src_idx_s = idx_r + 6'd1;
      end
      src_s = plain_src(src_idx_s, pre_len_r);
   end

   // Seed capture with zero substitution (an all-zero LFSR would lock up).
   always_comb begin
      seed_s = bus.mem_rdata[6:0];
      if (bus.mem_rdata[6:0] == 7'd0) begin
         seed_s = 7'h01;
      end else begin
         seed_s = bus.mem_rdata[6:0];
      end
   end

   // Ciphertext for the byte in WR; bit 7 of the plaintext is dropped.
   always_comb begin
      plain_s     = bus.mem_rdata[6:0];
      lfsr_next_s = lfsr_step(lfsr_r, taps_r);
      if (space_r) begin
         plain_s = SPACE7;
      end else begin
         plain_s = bus.mem_rdata[6:0];
      end
      cipher_s = plain_s ^ lfsr_r;
      if (state_r == WR) begin
         wdata_s = {parity7(cipher_s), cipher_s};
      end else begin
         wdata_s = 8'd0;
      end
   end

   // Control FSM with registered handshake and memory-port outputs.
   always_ff @(posedge clk) begin
      if (!init) begin
         state_r   <= IDLE;
         ack_r     <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= 8'd0;
         pre_len_r <= 8'd0;
         taps_r    <= 7'd0;
         lfsr_r    <= 7'h01;
         idx_r     <= 6'd0;
         space_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ack_r <= 1'b0;
               we_r  <= 1'b0;
               if (bus.req) begin
                  state_r <= CFG0;
                  addr_r  <= CFG_BASE;
               end else begin
                  state_r <= IDLE;
               end
            end
            CFG0: begin
               addr_r  <= CFG_BASE + 8'd1;
               state_r <= CFG1;
            end
            CFG1: begin
               pre_len_r <= bus.mem_rdata;
               addr_r    <= CFG_BASE + 8'd2;
               state_r   <= CFG2;
            end
            CFG2: begin
               taps_r  <= bus.mem_rdata[6:0];
               state_r <= CFG3;
            end
            CFG3: begin
               lfsr_r  <= seed_s;
               idx_r   <= 6'd0;
               space_r <= src_s[8];
               addr_r  <= src_s[7:0];
               state_r <= RD;
            end
            RD: begin
               we_r    <= 1'b1;
               addr_r  <= OUT_BASE + {2'b00, idx_r};
               state_r <= WR;
            end
            WR: begin
               we_r   <= 1'b0;
               lfsr_r <= lfsr_next_s;
               if (idx_r == LAST_IDX) begin
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r + 6'd1;
                  space_r <= src_s[8];
                  addr_r  <= src_s[7:0];
                  state_r <= RD;
               end
            end
            DONE: begin
               // ack drops on the same edge that sees req low; a held req
               // keeps the engine parked here so a run never restarts by itself.
               if (!bus.req) begin
                  ack_r   <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  ack_r   <= 1'b1;
                  state_r <= DONE;
               end
            end
            default: begin
               state_r <= IDLE;
               ack_r   <= 1'b0;
               we_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack       = ack_r;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_s;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// -----------------------------------------------------------------------------
// tb_lfsr_encrypt_engine
//
// Self-checking bench: behavioural synchronous data memory, a golden model that
// pushes the expected {address, data} of every write into a scoreboard queue,
// and a write monitor that pops and compares on each mem_we cycle.
// -----------------------------------------------------------------------------
module tb_lfsr_encrypt_engine;

   logic clk = 1'b0;
   logic init;

   lfsr_encrypt_engine_if bus();

   lfsr_encrypt_engine dut (
      .clk  (clk),
      .init (init),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  dm     [0:255];
   logic [15:0] sb_q   [$];
   logic [7:0]  exp_b  [0:63];
   logic [7:0]  save_b [0:63];
   int n_checks = 0;
   int n_pass   = 0;
   int wr_count = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Synchronous-read data memory.
   always @(posedge clk) begin
      if (bus.mem_we === 1'b1) dm[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= dm[bus.mem_addr];
   end

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      logic [15:0] e;
      if (bus.mem_we === 1'b1) begin
         wr_count++;
         check("wr_addr_min", 32'(bus.mem_addr >= 8'd64), 32'd1);
         check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(e[15:8]));
            check("wr_data", 32'(bus.mem_wdata), 32'(e[7:0]));
         end
      end
   end

   task automatic load_text(input string t);
      for (int k = 0; k <= 60; k++) dm[k] = (k < t.len()) ? t[k] : 8'h20;
   endtask

   task automatic load_random();
      for (int k = 0; k <= 60; k++) dm[k] = 8'($urandom_range(0, 255));
   endtask

   // Golden model straight from the cipher definition.
   task automatic build_expected(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
      logic [6:0] s;
      logic [7:0] p;
      logic [6:0] c;
      s = (seed[6:0] == 7'd0) ? 7'h01 : seed[6:0];
      for (int i = 0; i < 64; i++) begin
         if (i < int'(pre) || (i - int'(pre)) > 60) p = 8'h20;
         else p = dm[i - int'(pre)];
         c = p[6:0] ^ s;
         exp_b[i] = {^c, c};
         sb_q.push_back({8'(64 + i), exp_b[i]});
         s = {s[5:0], ^(s & taps[6:0])};
      end
   endtask

   task automatic do_run(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed, input int hold);
      int cnt;
      int base;
      dm[61] = pre;
      dm[62] = taps;
      dm[63] = seed;
      for (int k = 64; k < 128; k++) dm[k] = 8'h00;
      build_expected(pre, taps, seed);
      base = wr_count;
      @(negedge clk);
      bus.req = 1'b1;
      cnt = -1;
      do begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end while (bus.ack !== 1'b1 && cnt < 300);
      check("ack_latency", 32'(cnt), 32'd133);
      check("wr_count", 32'(wr_count - base), 32'd64);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      for (int i = 0; i < 64; i++) begin
         check("dm_out", 32'(dm[64 + i]), 32'(exp_b[i]));
         check("parity", 32'(dm[64 + i][7]), 32'(^dm[64 + i][6:0]));
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("ack_hold", 32'(bus.ack), 32'd1);
      end
      check("no_rerun", 32'(wr_count - base), 32'd64);
      bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ack_fall", 32'(bus.ack), 32'd0);
   endtask

   task automatic save_out();
      for (int i = 0; i < 64; i++) save_b[i] = dm[64 + i];
   endtask

   task automatic compare_saved(input string tag);
      for (int i = 0; i < 64; i++) check(tag, 32'(dm[64 + i]), 32'(save_b[i]));
   endtask

   task automatic reset_mid_run();
      int n;
      load_random();
      dm[61] = 8'd12;
      dm[62] = 8'h6A;
      dm[63] = 8'h2B;
      for (int k = 64; k < 128; k++) dm[k] = 8'h00;
      build_expected(8'd12, 8'h6A, 8'h2B);
      @(negedge clk);
      bus.req = 1'b1;
      n = 0;
      while (!(bus.mem_we === 1'b1 && bus.mem_addr == 8'd94) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach", 32'(bus.mem_addr), 32'd94);
      init    = 1'b0;
      bus.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_ack", 32'(bus.ack), 32'd0);
      check("mid_we", 32'(bus.mem_we), 32'd0);
      check("mid_addr", 32'(bus.mem_addr), 32'd0);
      check("mid_wdata", 32'(bus.mem_wdata), 32'd0);
      sb_q.delete();
      init = 1'b1;
   endtask

   logic [7:0] taps_tbl [0:8];

   initial begin
      taps_tbl[0] = 8'h60; taps_tbl[1] = 8'h48; taps_tbl[2] = 8'h78;
      taps_tbl[3] = 8'h72; taps_tbl[4] = 8'h6A; taps_tbl[5] = 8'h69;
      taps_tbl[6] = 8'h5C; taps_tbl[7] = 8'h7E; taps_tbl[8] = 8'h7B;
      for (int k = 0; k < 256; k++) dm[k] = 8'h00;
      init    = 1'b0;
      bus.req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_we", 32'(bus.mem_we), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
      init = 1'b1;

      // Known vector.
      load_text("Knowledge comes, but wisdom lingers");
      do_run(8'd10, 8'h60, 8'h01, 3);
      check("known_byte0", 32'(dm[64]), 32'h21);

      // All tap patterns with random seeds and pre_length 10..26.
      for (int t = 0; t < 9; t++) begin
         load_random();
         do_run(8'($urandom_range(10, 26)), taps_tbl[t], 8'($urandom_range(0, 255)), 0);
      end

      // Seed 0 behaves as seed 1.
      load_random();
      do_run(8'd15, 8'h48, 8'h00, 0);
      save_out();
      do_run(8'd15, 8'h48, 8'h01, 0);
      compare_saved("seed0_eq_seed1");

      // pre_length extremes.
      load_random();
      do_run(8'd0, 8'h78, 8'h35, 0);
      do_run(8'd200, 8'h7E, 8'h11, 0);

      // Plaintext bit 7 is discarded.
      load_text("Bit seven test message");
      dm[20] = 8'h9F;
      do_run(8'd5, 8'h5C, 8'h47, 0);
      save_out();
      dm[20] = 8'h1F;
      do_run(8'd5, 8'h5C, 8'h47, 0);
      compare_saved("bit7_ignored");

      // Reset in the middle of a run, then a full run.
      reset_mid_run();
      do_run(8'd12, 8'h6A, 8'h2B, 0);

      // Held req: no second run; re-raise gives identical output.
      load_random();
      do_run(8'd20, 8'h7B, 8'h5A, 10);
      save_out();
      do_run(8'd20, 8'h7B, 8'h5A, 0);
      compare_saved("rerun_same");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
